// File: rtl/hazard_ctrl.sv
// -----------------------------------------------------------------------------
// hazard_ctrl
//
// Hazard controller for the five-stage RV32I pipeline. It keeps a small record
// (valid, rd, reg_we, is_load) for the instructions in execute, memory and
// write-back. Those records drive the execute-stage forwarding selects, the
// load-use bubble and the squash of wrong-path instructions on a taken branch.
// Two wrapping event counters feed the performance CSRs.
//
// Handshake: there is no valid/ready pair here. hold freezes every record and
// both counters. The four control outputs are combinational in the cycle of
// the condition, and the pipeline registers act on them at the next edge.
//
// Ports:
//   clock, reset          core clock; synchronous active-high reset
//   hold                  memory-wait freeze of the whole pipeline
//   d_valid               decode stage holds a real instruction
//   d_rs1/d_rs2/d_rd      decode register indices
//   d_uses_rs1/rs2        decode instruction reads rs1 / rs2
//   d_reg_we, d_is_load   decode instruction writes rd / is a load
//   e_branch_taken        execute-stage branch or jump resolved taken
//   stall_fetch           hold PC and the F/D register
//   stall_decode          hold the D/E inputs
//   bubble_execute        load a NOP into D/E
//   flush_decode          clear F/D to a NOP
//   fwd_rs1_sel/rs2_sel   00 regfile, 01 memory result, 10 write-back result
//   stall_count           load-use bubbles inserted (wraps)
//   flush_count           taken-branch flushes (wraps)
// -----------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             hold,
    input  logic             d_valid,
    input  logic [4:0]       d_rs1,
    input  logic [4:0]       d_rs2,
    input  logic [4:0]       d_rd,
    input  logic             d_uses_rs1,
    input  logic             d_uses_rs2,
    input  logic             d_reg_we,
    input  logic             d_is_load,
    input  logic             e_branch_taken,
    output logic             stall_fetch,
    output logic             stall_decode,
    output logic             bubble_execute,
    output logic             flush_decode,
    output logic [1:0]       fwd_rs1_sel,
    output logic [1:0]       fwd_rs2_sel,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       reg_we;
        logic       is_load;
    } stage_rec_t;

    typedef struct packed {
        stage_rec_t base;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       uses_rs1;
        logic       uses_rs2;
    } ex_rec_t;

    // What the pipeline does at the end of this cycle.
    typedef enum logic [1:0] {
        ACT_ADVANCE,
        ACT_HOLD,
        ACT_FLUSH,
        ACT_BUBBLE
    } action_e;

    ex_rec_t          ex_q;
    stage_rec_t       mem_q;
    stage_rec_t       wb_q;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    ex_rec_t          d_rec;
    logic             load_use;
    action_e          action;

    // x0 is hard-wired zero, so a write to it is never a forwarding source.
    function automatic logic is_writer(input stage_rec_t rec, input logic [4:0] idx);
        return rec.valid & rec.reg_we & (rec.rd == idx) & (rec.rd != 5'd0);
    endfunction

    // MEM holds the younger result, so it wins over WB on a double match.
    function automatic logic [1:0] fwd_sel(input logic uses, input logic [4:0] idx,
                                           input stage_rec_t mem, input stage_rec_t wb);
        if (uses && is_writer(mem, idx))     return 2'b01;
        else if (uses && is_writer(wb, idx)) return 2'b10;
        else                                 return 2'b00;
    endfunction

    always_comb begin
        d_rec               = '0;
        d_rec.base.valid    = d_valid;
        d_rec.base.rd       = d_rd;
        d_rec.base.reg_we   = d_reg_we;
        d_rec.base.is_load  = d_is_load;
        d_rec.rs1           = d_rs1;
        d_rec.rs2           = d_rs2;
        d_rec.uses_rs1      = d_uses_rs1;
        d_rec.uses_rs2      = d_uses_rs2;
    end

    assign load_use = d_valid & ex_q.base.valid & ex_q.base.is_load & ex_q.base.reg_we
                    & (ex_q.base.rd != 5'd0)
                    & ((d_uses_rs1 & (d_rs1 == ex_q.base.rd))
                     | (d_uses_rs2 & (d_rs2 == ex_q.base.rd)));

    // Priority: reset, hold, taken branch, load-use. A branch beats load-use
    // because the decode instruction is then on the wrong path anyway.
    always_comb begin
        action         = ACT_ADVANCE;
        stall_fetch    = 1'b0;
        stall_decode   = 1'b0;
        bubble_execute = 1'b0;
        flush_decode   = 1'b0;
        if (reset) begin
            action = ACT_ADVANCE;
        end else if (hold) begin
            action       = ACT_HOLD;
            stall_fetch  = 1'b1;
            stall_decode = 1'b1;
        end else if (e_branch_taken) begin
            action         = ACT_FLUSH;
            bubble_execute = 1'b1;
            flush_decode   = 1'b1;
        end else if (load_use) begin
            action         = ACT_BUBBLE;
            stall_fetch    = 1'b1;
            stall_decode   = 1'b1;
            bubble_execute = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            unique case (action)
                ACT_HOLD: begin
                    ex_q  <= ex_q;
                    mem_q <= mem_q;
                    wb_q  <= wb_q;
                end
                ACT_FLUSH: begin
                    ex_q        <= '0;
                    mem_q       <= ex_q.base;
                    wb_q        <= mem_q;
                    flush_cnt_q <= flush_cnt_q + CNT_W'(1);
                end
                ACT_BUBBLE: begin
                    ex_q        <= '0;
                    mem_q       <= ex_q.base;
                    wb_q        <= mem_q;
                    stall_cnt_q <= stall_cnt_q + CNT_W'(1);
                end
                default: begin
                    ex_q  <= d_rec;
                    mem_q <= ex_q.base;
                    wb_q  <= mem_q;
                end
            endcase
        end
    end

    assign fwd_rs1_sel = fwd_sel(ex_q.uses_rs1, ex_q.rs1, mem_q, wb_q);
    assign fwd_rs2_sel = fwd_sel(ex_q.uses_rs2, ex_q.rs2, mem_q, wb_q);
    assign stall_count = stall_cnt_q;
    assign flush_count = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl
//
// Bench for hazard_ctrl with 4-bit counters. Each vector is one clock cycle:
// the decode-side inputs applied in that cycle and every output expected in
// that same cycle. Expected words are queued when a vector is driven and
// popped when the outputs are sampled mid-cycle.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl;

    localparam int CNT_W = 4;
    localparam int EXP_W = 16;

    // Expected word: {sf, sd, bx, fd, fwd1, fwd2, stall_count, flush_count}
    typedef struct packed {
        logic             chk;
        logic             rst;
        logic             hold;
        logic             br;
        logic             dv;
        logic [4:0]       rs1;
        logic [4:0]       rs2;
        logic [4:0]       rd;
        logic             u1;
        logic             u2;
        logic             we;
        logic             ld;
        logic [EXP_W-1:0] exp;
    } vec_t;

    // ---------------- clock / reset ----------------
    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic             hold = 1'b0;
    logic             d_valid = 1'b0;
    logic [4:0]       d_rs1 = '0;
    logic [4:0]       d_rs2 = '0;
    logic [4:0]       d_rd = '0;
    logic             d_uses_rs1 = 1'b0;
    logic             d_uses_rs2 = 1'b0;
    logic             d_reg_we = 1'b0;
    logic             d_is_load = 1'b0;
    logic             e_branch_taken = 1'b0;
    logic             stall_fetch;
    logic             stall_decode;
    logic             bubble_execute;
    logic             flush_decode;
    logic [1:0]       fwd_rs1_sel;
    logic [1:0]       fwd_rs2_sel;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    always #5 clock = ~clock;

    hazard_ctrl #(.CNT_W(CNT_W)) dut (
        .clock          (clock),
        .reset          (reset),
        .hold           (hold),
        .d_valid        (d_valid),
        .d_rs1          (d_rs1),
        .d_rs2          (d_rs2),
        .d_rd           (d_rd),
        .d_uses_rs1     (d_uses_rs1),
        .d_uses_rs2     (d_uses_rs2),
        .d_reg_we       (d_reg_we),
        .d_is_load      (d_is_load),
        .e_branch_taken (e_branch_taken),
        .stall_fetch    (stall_fetch),
        .stall_decode   (stall_decode),
        .bubble_execute (bubble_execute),
        .flush_decode   (flush_decode),
        .fwd_rs1_sel    (fwd_rs1_sel),
        .fwd_rs2_sel    (fwd_rs2_sel),
        .stall_count    (stall_count),
        .flush_count    (flush_count)
    );

    // ---------------- scoreboard ----------------
    logic [EXP_W-1:0] exp_q[$];
    int               checks = 0;
    int               failures = 0;
    vec_t             tbl[$];

    function automatic vec_t instr(input logic dv, input logic [4:0] rs1, input logic [4:0] rs2,
                                   input logic [4:0] rd, input logic u1, input logic u2,
                                   input logic we, input logic ld);
        vec_t v;
        v     = '0;
        v.chk = 1'b1;
        v.dv  = dv;
        v.rs1 = rs1;
        v.rs2 = rs2;
        v.rd  = rd;
        v.u1  = u1;
        v.u2  = u2;
        v.we  = we;
        v.ld  = ld;
        return v;
    endfunction

    // ctl = {stall_fetch, stall_decode, bubble_execute, flush_decode}
    function automatic vec_t row(input vec_t base, input logic rst, input logic hld, input logic br,
                                 input logic [3:0] ctl, input logic [1:0] f1, input logic [1:0] f2,
                                 input logic [3:0] sc, input logic [3:0] fc);
        vec_t v;
        v      = base;
        v.rst  = rst;
        v.hold = hld;
        v.br   = br;
        v.exp  = {ctl, f1, f2, sc, fc};
        return v;
    endfunction

    task automatic check_out(input int tag);
        logic [EXP_W-1:0] act;
        logic [EXP_W-1:0] e;
        act = {stall_fetch, stall_decode, bubble_execute, flush_decode,
               fwd_rs1_sel, fwd_rs2_sel, stall_count, flush_count};
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL cycle_%0d: no expected entry queued, got %h", tag, act);
        end else begin
            e = exp_q.pop_front();
            if (act !== e) begin
                failures++;
                $display("FAIL cycle_%0d: got ctl=%b fwd=%b/%b stall=%0d flush=%0d, required ctl=%b fwd=%b/%b stall=%0d flush=%0d",
                         tag, act[15:12], act[11:10], act[9:8], act[7:4], act[3:0],
                         e[15:12], e[11:10], e[9:8], e[7:4], e[3:0]);
            end
        end
    endtask

    // ---------------- driver ----------------
    task automatic apply(input vec_t v, input int tag);
        @(posedge clock);
        #1;
        reset          = v.rst;
        hold           = v.hold;
        e_branch_taken = v.br;
        d_valid        = v.dv;
        d_rs1          = v.rs1;
        d_rs2          = v.rs2;
        d_rd           = v.rd;
        d_uses_rs1     = v.u1;
        d_uses_rs2     = v.u2;
        d_reg_we       = v.we;
        d_is_load      = v.ld;
        if (v.chk) exp_q.push_back(v.exp);
        #2;
        if (v.chk) check_out(tag);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        vec_t idle, add5, sub6, and9, or8, add0, or8_x0, lw3, add4, nouse, lw0, use0, add9, add4b, rnd;

        idle   = instr(0,  0,  0, 0, 0, 0, 0, 0);
        add5   = instr(1,  1,  2, 5, 1, 1, 1, 0);
        sub6   = instr(1,  5,  7, 6, 1, 1, 1, 0);
        and9   = instr(1, 10, 11, 9, 1, 1, 1, 0);
        or8    = instr(1,  5,  5, 8, 1, 1, 1, 0);
        add0   = instr(1,  1,  2, 0, 1, 1, 1, 0);
        or8_x0 = instr(1,  0,  0, 8, 1, 1, 1, 0);
        lw3    = instr(1,  2,  0, 3, 1, 0, 1, 1);
        add4   = instr(1,  3,  1, 4, 1, 1, 1, 0);
        nouse  = instr(1,  3,  6, 7, 0, 1, 1, 0);
        lw0    = instr(1,  2,  0, 0, 1, 0, 1, 1);
        use0   = instr(1,  0,  1, 4, 1, 1, 1, 0);
        add9   = instr(1,  1,  2, 9, 1, 1, 1, 0);
        add4b  = instr(1,  1,  3, 4, 1, 1, 1, 0);

        // Reset held three cycles with random decode, hold and branch inputs.
        for (int i = 0; i < 3; i++) begin
            rnd = instr(1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom),
                        1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            tbl.push_back(row(rnd, 1, 1'($urandom), 1'($urandom), 4'b0000, 0, 0, 0, 0));
        end
        tbl.push_back(row(idle,   0, 0, 0, 4'b0000, 0, 0, 0, 0));
        // Back-to-back ALU forward from MEM.
        tbl.push_back(row(add5,   0, 0, 0, 4'b0000, 0, 0, 0, 0));
        tbl.push_back(row(sub6,   0, 0, 0, 4'b0000, 0, 0, 0, 0));
        tbl.push_back(row(idle,   0, 0, 0, 4'b0000, 1, 0, 0, 0));
        tbl.push_back(row(idle,   0, 0, 0, 4'b0000, 0, 0, 0, 0));
        // Distance-2 forward from WB.
        tbl.push_back(row(add5,   0, 0, 0, 4'b0000, 0, 0, 0, 0));
        tbl.push_back(row(and9,   0, 0, 0, 4'b0000, 0, 0, 0, 0));
        tbl.push_back(row(sub6,   0, 0, 0, 4'b0000, 0, 0, 0, 0));
        tbl.push_back(row(idle,   0, 0, 0, 4'b0000, 2, 0, 0, 0));
        tbl.push_back(row(idle,   0, 0, 0, 4'b0000, 0, 0, 0, 0));
        // Double match: MEM wins over WB on both operands.
        tbl.push_back(row(add5,   0, 0, 0, 4'b0000, 0, 0, 0, 0));
        tbl.push_back(row(add5,   0, 0, 0, 4'b0000, 0, 0, 0, 0));
        tbl.push_back(row(or8,    0, 0, 0, 4'b0000, 0, 0, 0, 0));
        tbl.push_back(row(idle,   0, 0, 0, 4'b0000, 1, 1, 0, 0));
        tbl.push_back(row(idle,   0, 0, 0, 4'b0000, 0, 0, 0, 0));
        // Same with x0: never forwarded.
        tbl.push_back(row(add0,   0, 0, 0, 4'b0000, 0, 0, 0, 0));
        tbl.push_back(row(add0,   0, 0, 0, 4'b0000, 0, 0, 0, 0));
        tbl.push_back(row(or8_x0, 0, 0, 0, 4'b0000, 0, 0, 0, 0));
        tbl.push_back(row(idle,   0, 0, 0, 4'b0000, 0, 0, 0, 0));
        tbl.push_back(row(idle,   0, 0, 0, 4'b0000, 0, 0, 0, 0));
        // Load-use: one bubble, then forward from WB.
        tbl.push_back(row(lw3,    0, 0, 0, 4'b0000, 0, 0, 0, 0));
        tbl.push_back(row(add4,   0, 0, 0, 4'b1110, 0, 0, 0, 0));
        tbl.push_back(row(add4,   0, 0, 0, 4'b0000, 0, 0, 1, 0));
        tbl.push_back(row(idle,   0, 0, 0, 4'b0000, 2, 0, 1, 0));
        tbl.push_back(row(idle,   0, 0, 0, 4'b0000, 0, 0, 1, 0));
        // Matching index with uses_rs1=0: no stall, no forward.
        tbl.push_back(row(lw3,    0, 0, 0, 4'b0000, 0, 0, 1, 0));
        tbl.push_back(row(nouse,  0, 0, 0, 4'b0000, 0, 0, 1, 0));
        tbl.push_back(row(idle,   0, 0, 0, 4'b0000, 0, 0, 1, 0));
        tbl.push_back(row(idle,   0, 0, 0, 4'b0000, 0, 0, 1, 0));
        // Load into x0 never stalls.
        tbl.push_back(row(lw0,    0, 0, 0, 4'b0000, 0, 0, 1, 0));
        tbl.push_back(row(use0,   0, 0, 0, 4'b0000, 0, 0, 1, 0));
        tbl.push_back(row(idle,   0, 0, 0, 4'b0000, 0, 0, 1, 0));
        // Branch in the same cycle as a load-use: flush wins.
        tbl.push_back(row(lw3,    0, 0, 0, 4'b0000, 0, 0, 1, 0));
        tbl.push_back(row(add4,   0, 0, 1, 4'b0011, 0, 0, 1, 0));
        tbl.push_back(row(idle,   0, 0, 0, 4'b0000, 0, 0, 1, 1));
        // Hold with branch: frozen (forwards stay 01), then one flush.
        tbl.push_back(row(add5,   0, 0, 0, 4'b0000, 0, 0, 1, 1));
        tbl.push_back(row(or8,    0, 0, 0, 4'b0000, 0, 0, 1, 1));
        tbl.push_back(row(add9,   0, 1, 1, 4'b1100, 1, 1, 1, 1));
        tbl.push_back(row(add9,   0, 1, 1, 4'b1100, 1, 1, 1, 1));
        tbl.push_back(row(add9,   0, 0, 1, 4'b0011, 1, 1, 1, 1));
        tbl.push_back(row(idle,   0, 0, 0, 4'b0000, 0, 0, 1, 2));
        tbl.push_back(row(idle,   0, 0, 0, 4'b0000, 0, 0, 1, 2));
        // Hold over a load-use: no bubble, no count until hold drops.
        tbl.push_back(row(lw3,    0, 0, 0, 4'b0000, 0, 0, 1, 2));
        tbl.push_back(row(add4,   0, 1, 0, 4'b1100, 0, 0, 1, 2));
        tbl.push_back(row(add4,   0, 0, 0, 4'b1110, 0, 0, 1, 2));
        tbl.push_back(row(add4,   0, 0, 0, 4'b0000, 0, 0, 2, 2));
        tbl.push_back(row(idle,   0, 0, 0, 4'b0000, 2, 0, 2, 2));
        // Reset in the middle of a load-use; the first reset cycle is not compared.
        tbl.push_back(row(lw3,    0, 0, 0, 4'b0000, 0, 0, 2, 2));
        tbl.push_back(row(add4,   1, 0, 0, 4'b0000, 0, 0, 0, 0));
        tbl[tbl.size()-1].chk = 1'b0;
        tbl.push_back(row(add4,   1, 0, 0, 4'b0000, 0, 0, 0, 0));
        tbl.push_back(row(add4,   0, 0, 0, 4'b0000, 0, 0, 0, 0));
        tbl.push_back(row(idle,   0, 0, 0, 4'b0000, 0, 0, 0, 0));
        // Reset overriding a taken branch.
        tbl.push_back(row(add4,   1, 1, 1, 4'b0000, 0, 0, 0, 0));
        tbl.push_back(row(idle,   0, 0, 0, 4'b0000, 0, 0, 0, 0));

        foreach (tbl[i]) apply(tbl[i], i);

        // Counter wrap: 17 load-use stalls into a 4-bit counter.
        for (int i = 0; i < 17; i++) begin
            apply(row(lw3,   0, 0, 0, 4'b0000, 0, (i > 0) ? 2'b10 : 2'b00, 4'(i), 0), 1000 + 3*i);
            apply(row(add4b, 0, 0, 0, 4'b1110, 0, 0, 4'(i), 0), 1001 + 3*i);
            apply(row(add4b, 0, 0, 0, 4'b0000, 0, 0, 4'(i + 1), 0), 1002 + 3*i);
        end
        apply(row(idle, 0, 0, 0, 4'b0000, 0, 2, 1, 0), 2000);

        // ---------------- report ----------------
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL leftover_queue: got %0d entries, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the five-stage RV32I core. It tracks the destination register of every in-flight instruction in execute, memory and write-back. From that it drives the forwarding selects of the execute-stage operand muxes and detects load-use hazards, inserting one bubble for each. It also squashes wrong-path instructions on a taken branch, and keeps stall/flush event counters for the performance CSRs.

## Interface
Parameters:
- CNT_W, 32, width of the stall and flush event counters

Ports:
- clock  in  1  core clock
- reset  in  1  synchronous, active-high; one clock; all state cleared on the rising edge while high
- hold  in  1  memory-wait freeze of the whole pipeline
- d_valid  in  1  decode stage holds a real instruction
- d_rs1, d_rs2, d_rd  in  5 each  decode-stage register indices
- d_uses_rs1, d_uses_rs2  in  1 each  instruction reads rs1 / rs2
- d_reg_we  in  1  instruction writes rd
- d_is_load  in  1  instruction is a load
- e_branch_taken  in  1  execute-stage branch/jump resolved taken
- stall_fetch  out  1  hold PC and the F/D register
- stall_decode  out  1  hold the D/E inputs (decode re-presents)
- bubble_execute  out  1  load a NOP into D/E
- flush_decode  out  1  clear F/D to a NOP
- fwd_rs1_sel, fwd_rs2_sel  out  2 each  execute operand source: 00 register file, 01 memory-stage result, 10 write-back result, 11 unused
- stall_count  out  CNT_W  load-use bubbles inserted
- flush_count  out  CNT_W  taken-branch flushes

## Operation
Per-stage records are registered: EX, MEM and WB. Each record holds valid, rd, reg_we and is_load. EX additionally holds rs1, rs2, uses_rs1 and uses_rs2.

Writer definition:
- A stage is a writer for register r when valid & reg_we & rd==r & rd!=0.
- x0 is never forwarded and never causes a stall.

Load-use hazard (lu), combinational:
- d_valid & EX.valid & EX.is_load & EX.reg_we & EX.rd!=0
- and either (d_uses_rs1 & d_rs1==EX.rd) or (d_uses_rs2 & d_rs2==EX.rd).

Priority per cycle, highest first:
- **hold:** all records keep their value. stall_fetch=stall_decode=1, bubble_execute=0, flush_decode=0. Counters unchanged. e_branch_taken is ignored; upstream keeps it asserted until hold falls.
- **e_branch_taken:** flush_decode=1, bubble_execute=1, stall_*=0. EX<=invalid, MEM<=EX, WB<=MEM. flush_count+=1. Any lu in the same cycle is ignored, because the decode instruction is wrong-path.
- **lu:** stall_fetch=stall_decode=1, bubble_execute=1. EX<=invalid, MEM<=EX, WB<=MEM. stall_count+=1.
- **otherwise:** EX<={decode fields, valid=d_valid}, MEM<=EX, WB<=MEM. All control outputs are 0.

Forwarding, combinational from the records, per operand n in {rs1, rs2}:
- 01 if EX.uses_rsn and MEM is a writer of EX.rsn.
- Otherwise 10 if EX.uses_rsn and WB is a writer of EX.rsn.
- Otherwise 00.
- MEM has priority over WB when both match.

A load never sits in MEM while its consumer is in EX; the lu bubble guarantees this.

Counters wrap modulo 2^CNT_W with no saturation.

## Timing
- **Reset:** all records invalid and fields 0. Every output is 0, including fwd sels=00 and both counters=0. Reset overrides hold and branch.
- **Control outputs:** stall_fetch, stall_decode, bubble_execute and flush_decode are combinational in the same cycle as the condition (zero latency). The consumer registers them on the next edge.
- **Forward selects:** valid throughout the cycle the instruction is in EX; they depend only on registered state.
- **Load-use stall:** exactly one bubble. On the next cycle the load is in MEM, lu=0, and the consumer enters EX. One cycle later the load is in WB, and the consumer's select is 10 provided nothing younger in MEM writes the same register.
- **Counter updates:** counters update on the edge that ends the event cycle.
- **Reset mid-stall or mid-flush:** the pending bubble is discarded and the next non-reset cycle behaves as after reset.

## Test plan
- **Reset:** hold reset 3 cycles with random inputs → all outputs 0 and both counters 0. Release → first idle cycle shows all 0.
- **ALU back-to-back and distance-2 forwarding:**
  - Issue add x5 then sub x6,x5,x7 → in the sub's EX cycle fwd_rs1_sel=01 and fwd_rs2_sel=00.
  - Insert one unrelated instruction between them → fwd_rs1_sel=10.
- **Double match and x0:**
  - Issue add x5; add x5; or x8,x5,x5 → both selects=01, because MEM wins.
  - Repeat with rd=x0 throughout → both selects=00.
- **Load-use:** issue lw x3 then add x4,x3,x1 →
  - One cycle with stall_fetch=stall_decode=bubble_execute=1, then stall_count=1.
  - Next cycle no stall.
  - When the add is in EX, fwd_rs1_sel=10.
  - Also: a lw followed by an instruction with uses_rs1=0 matching rd → no stall.
- **Branch against load-use:**
  - Assert e_branch_taken in the same cycle lu would fire → flush_decode=1, bubble_execute=1, stall_fetch=0, flush_count=1, stall_count unchanged.
  - Assert hold together with branch → no flush, records frozen for the hold duration.
  - Release hold with branch still asserted → flush occurs once.
- **Counter wrap:** with CNT_W=4, force 17 load-use stalls → stall_count=1.
